veri_paketleyici: RTL and testbench

- Parametrised successor to the fixed 32→64-bit fill register.
- Accepts a stream of `W`-bit words over a valid/ready handshake and packs `N` consecutive words into one `N*W`-bit output word.
- Adds output backpressure, a flush command that emits partial words with a word count, and a selectable packing order.
- Sits between narrow data sources (memory readers, serial front-ends) and wide storage/processing stages.

---
 rtl/paket_pkg.sv | 17 +
 rtl/paket_cikis_reg.sv | 53 +++++
 rtl/veri_paketleyici.sv | 89 ++++++++
 tb/tb_veri_paketleyici.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paket_pkg.sv
// Shared widths and packing-order constants for the word packer and its
// output register.
package paket_pkg;

   localparam int ILK_LSB = 0;
   localparam int ILK_MSB = 1;

   // The fill counter never needs to exceed N-1.
   function automatic int say_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int adet_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/paket_cikis_reg.sv
// Output holding register for a valid/ready stream: loads on request, holds
// while the consumer stalls, and drops valid once drained with nothing new.
module paket_cikis_reg #(
   parameter int DW = 64,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          yukle_i,
   input  logic [DW-1:0] veri_i,
   input  logic [AW-1:0] adet_i,
   input  logic          hazir_i,
   output logic [DW-1:0] veri_o,
   output logic [AW-1:0] adet_o,
   output logic          gecerli_o,
   output logic          bos_o
);

   logic [DW-1:0] veri_q, veri_d;
   logic [AW-1:0] adet_q, adet_d;
   logic          gecerli_q, gecerli_d;

   always_comb begin
      veri_d    = veri_q;
      adet_d    = adet_q;
      gecerli_d = gecerli_q;
      if (yukle_i) begin
         veri_d    = veri_i;
         adet_d    = adet_i;
         gecerli_d = 1'b1;
      end else if (gecerli_q && hazir_i) begin
         gecerli_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         veri_q    <= '0;
         adet_q    <= '0;
         gecerli_q <= 1'b0;
      end else begin
         veri_q    <= veri_d;
         adet_q    <= adet_d;
         gecerli_q <= gecerli_d;
      end
   end

   assign veri_o    = veri_q;
   assign adet_o    = adet_q;
   assign gecerli_o = gecerli_q;
   assign bos_o     = !gecerli_q || hazir_i;

endmodule

// File: rtl/veri_paketleyici.sv
// Packs N consecutive W-bit stream words into one N*W-bit output word, with
// flush of partial words, output backpressure and selectable packing order.
module veri_paketleyici
   import paket_pkg::*;
#(
   parameter int W       = 32,
   parameter int N       = 2,
   parameter int MSB_ILK = ILK_LSB
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [W-1:0]           veri,
   input  logic                   veri_gecerli,
   output logic                   veri_hazir,
   input  logic                   bosalt,
   output logic [N*W-1:0]         depo,
   output logic [adet_w(N)-1:0]   adet,
   output logic                   depo_gecerli,
   input  logic                   depo_hazir
);

   localparam int SAY_W  = say_w(N);
   localparam int ADET_W = adet_w(N);
   localparam logic [SAY_W-1:0] SON = SAY_W'(N - 1);

   if (N < 2 || W < 1) begin : g_param_hata
      $error("veri_paketleyici: N must be >= 2 and W >= 1");
   end

   logic [N*W-1:0]    acc_q, acc_d, acc_yeni;
   logic [SAY_W-1:0]  say_q, say_d, slot;
   logic [ADET_W-1:0] adet_etkin;
   logic              cikis_bos, kabul, dolu, bosalt_gec, tamamla;

   // A full accumulator may only take its last word if the output can move.
   assign veri_hazir = rst_n && !(say_q == SON && !cikis_bos);
   assign kabul      = veri_gecerli && veri_hazir;
   assign slot       = (MSB_ILK == ILK_MSB) ? (SON - say_q) : say_q;
   assign adet_etkin = ADET_W'(say_q) + ADET_W'(kabul);
   assign dolu       = kabul && (say_q == SON);
   assign bosalt_gec = bosalt && cikis_bos && (adet_etkin != '0);
   assign tamamla    = dolu || bosalt_gec;

   always_comb begin
      acc_yeni = acc_q;
      for (int i = 0; i < N; i++) begin
         if (kabul && slot == SAY_W'(i)) begin
            acc_yeni[i*W +: W] = veri;
         end
      end
   end

   always_comb begin
      acc_d = acc_yeni;
      say_d = kabul ? say_q + SAY_W'(1) : say_q;
      if (tamamla) begin
         acc_d = '0;
         say_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         say_q <= '0;
      end else begin
         acc_q <= acc_d;
         say_q <= say_d;
      end
   end

   // acc_yeni already holds zeros in unfilled slots, so partial words come out clean.
   paket_cikis_reg #(
      .DW (N*W),
      .AW (ADET_W)
   ) u_cikis (
      .clk       (clk),
      .rst_n     (rst_n),
      .yukle_i   (tamamla),
      .veri_i    (acc_yeni),
      .adet_i    (adet_etkin),
      .hazir_i   (depo_hazir),
      .veri_o    (depo),
      .adet_o    (adet),
      .gecerli_o (depo_gecerli),
      .bos_o     (cikis_bos)
   );

endmodule

// File: tb/tb_veri_paketleyici.sv
// Bench for veri_paketleyici: two N=2 instances (both packing orders) share
// stimulus, an N=4 instance covers flush; a word-queue model checks every cycle.
module tb_veri_paketleyici;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [31:0]  va;
   logic         vga, bos_a, dh_a;
   logic         hz_a, hz_b, dv_a, dv_b;
   logic [63:0]  d_a, d_b;
   logic [1:0]   ad_a, ad_b;

   logic [31:0]  vc;
   logic         vgc, bos_c, dh_c, hz_c, dv_c;
   logic [127:0] d_c;
   logic [2:0]   ad_c;

   int errors = 0;
   int checks = 0;

   veri_paketleyici #(.W(32), .N(2), .MSB_ILK(0)) u_a (
      .clk(clk), .rst_n(rst_n), .veri(va), .veri_gecerli(vga), .veri_hazir(hz_a),
      .bosalt(bos_a), .depo(d_a), .adet(ad_a), .depo_gecerli(dv_a), .depo_hazir(dh_a));

   veri_paketleyici #(.W(32), .N(2), .MSB_ILK(1)) u_b (
      .clk(clk), .rst_n(rst_n), .veri(va), .veri_gecerli(vga), .veri_hazir(hz_b),
      .bosalt(bos_a), .depo(d_b), .adet(ad_b), .depo_gecerli(dv_b), .depo_hazir(dh_a));

   veri_paketleyici #(.W(32), .N(4), .MSB_ILK(0)) u_c (
      .clk(clk), .rst_n(rst_n), .veri(vc), .veri_gecerli(vgc), .veri_hazir(hz_c),
      .bosalt(bos_c), .depo(d_c), .adet(ad_c), .depo_gecerli(dv_c), .depo_hazir(dh_c));

   // Model: words collected per instance, expected outputs in a small FIFO.
   logic [31:0]  part_w [3][4];
   int           part_n [3];
   logic [127:0] exp_d  [3][8];
   int           exp_a  [3][8];
   int           rd [3], wr [3], nout [3];
   bit           last_acc_a, last_acc_c;

   task automatic clear_all();
      for (int k = 0; k < 3; k++) begin
         part_n[k] = 0;
         rd[k] = 0;
         wr[k] = 0;
      end
   endtask

   task automatic mdl(input int k, input int n, input bit msb, input bit vg, input bit hz,
                      input logic [31:0] w, input bit bs, input bit dv, input bit dh,
                      input logic [127:0] dd, input int da);
      logic [127:0] p;
      int slot;
      checks++;
      if (dv) begin
         if (wr[k] == rd[k]) begin
            errors++;
            $display("FAIL out%0d_spurious: depo_gecerli=1 got, 0 expected", k);
         end else if (dd !== exp_d[k][rd[k] & 7] || da != exp_a[k][rd[k] & 7]) begin
            errors++;
            $display("FAIL out%0d_data: depo=%h adet=%0d got, depo=%h adet=%0d expected",
                     k, dd, da, exp_d[k][rd[k] & 7], exp_a[k][rd[k] & 7]);
         end
         if (dh && wr[k] != rd[k]) begin
            rd[k]++;
            nout[k]++;
         end
      end else if (wr[k] != rd[k]) begin
         errors++;
         $display("FAIL out%0d_missing: depo_gecerli=0 got, 1 expected", k);
      end
      if (vg && hz) begin
         part_w[k][part_n[k]] = w;
         part_n[k]++;
      end
      if (part_n[k] == n || (bs && (!dv || dh) && part_n[k] > 0)) begin
         p = '0;
         for (int i = 0; i < part_n[k]; i++) begin
            slot = msb ? (n - 1 - i) : i;
            p[slot*32 +: 32] = part_w[k][i];
         end
         exp_d[k][wr[k] & 7] = p;
         exp_a[k][wr[k] & 7] = part_n[k];
         wr[k]++;
         part_n[k] = 0;
      end
   endtask

   // Single compare point: the model runs on the falling edge inside tick().
   task automatic tick();
      @(negedge clk);
      if (rst_n) begin
         last_acc_a = vga && hz_a;
         last_acc_c = vgc && hz_c;
         mdl(0, 2, 1'b0, vga, hz_a, va, bos_a, dv_a, dh_a, 128'(d_a), int'(ad_a));
         mdl(1, 2, 1'b1, vga, hz_b, va, bos_a, dv_b, dh_a, 128'(d_b), int'(ad_b));
         mdl(2, 4, 1'b0, vgc, hz_c, vc, bos_c, dv_c, dh_c, d_c, int'(ad_c));
      end else begin
         last_acc_a = 1'b0;
         last_acc_c = 1'b0;
         clear_all();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, expv);
      end
   endtask

   task automatic send_a(input logic [31:0] w);
      int n = 0;
      va  = w;
      vga = 1'b1;
      do begin
         tick();
         n++;
      end while (!last_acc_a && n < 50);
      if (!last_acc_a) begin
         errors++;
         $display("FAIL send_a_timeout: word %h not accepted, accept expected", w);
      end
      vga = 1'b0;
   endtask

   task automatic send_c(input logic [31:0] w, input bit bs);
      int n = 0;
      vc    = w;
      vgc   = 1'b1;
      bos_c = bs;
      do begin
         tick();
         n++;
      end while (!last_acc_c && n < 50);
      if (!last_acc_c) begin
         errors++;
         $display("FAIL send_c_timeout: word %h not accepted, accept expected", w);
      end
      vgc   = 1'b0;
      bos_c = 1'b0;
   endtask

   logic [31:0] dosya [14];
   logic [31:0] ka, kb, kc;
   int i, cyc, n0;

   initial begin
      rst_n = 1'b0;
      va = '0; vga = 1'b0; bos_a = 1'b0; dh_a = 1'b1;
      vc = '0; vgc = 1'b0; bos_c = 1'b0; dh_c = 1'b1;
      last_acc_a = 1'b0; last_acc_c = 1'b0;
      clear_all();
      for (int k = 0; k < 3; k++) nout[k] = 0;
      #1;
      chk("rst_hazir",   128'(hz_a), 128'(0));
      chk("rst_gecerli", 128'(dv_a), 128'(0));
      chk("rst_depo",    128'(d_a),  128'(0));
      chk("rst_adet",    128'(ad_a), 128'(0));
      chk("rst_depo_c",  d_c,        128'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Continuous stream, both packing orders
      send_a(32'h11111111);
      send_a(32'h22222222);
      chk("t1_depo_lsb", 128'(d_a),  128'(64'h22222222_11111111));
      chk("t1_adet",     128'(ad_a), 128'(2));
      chk("t1_gecerli",  128'(dv_a), 128'(1));
      chk("t2_depo_msb", 128'(d_b),  128'(64'h11111111_22222222));
      tick();
      chk("t1_drained",  128'(dv_a), 128'(0));

      // Backpressure: 14 words, consumer stalled after the first output
      for (int j = 0; j < 14; j++) dosya[j] = 32'hA0000000 + 32'(j * 32'h01010101);
      n0 = nout[0];
      dh_a = 1'b0;
      i = 0;
      for (int c = 0; c < 8; c++) begin
         va = dosya[i];
         vga = 1'b1;
         tick();
         if (last_acc_a) i++;
      end
      chk("t3_absorbed", 128'(i),    128'(3));
      chk("t3_hazir",    128'(hz_a), 128'(0));
      chk("t3_hold",     128'(d_a),  128'({dosya[1], dosya[0]}));
      dh_a = 1'b1;
      cyc = 0;
      while (i < 14 && cyc < 40) begin
         va = dosya[i];
         vga = 1'b1;
         tick();
         if (last_acc_a) i++;
         cyc++;
      end
      vga = 1'b0;
      chk("t3_resume_cycles", 128'(cyc), 128'(11));
      tick();
      tick();
      chk("t3_outputs", 128'(nout[0] - n0), 128'(7));

      // Drain and completion on the same edge
      dh_a = 1'b0;
      send_a(32'h55550000);
      send_a(32'h55551111);
      send_a(32'h55552222);
      chk("t5_hazir_low", 128'(hz_a), 128'(0));
      chk("t5_old",       128'(d_a),  128'(64'h55551111_55550000));
      va = 32'h55553333;
      vga = 1'b1;
      dh_a = 1'b1;
      tick();
      vga = 1'b0;
      chk("t5_accept",  128'(last_acc_a), 128'(1));
      chk("t5_gecerli", 128'(dv_a),       128'(1));
      chk("t5_new",     128'(d_a),        128'(64'h55553333_55552222));
      tick();
      chk("t5_drained", 128'(dv_a), 128'(0));

      // Reset mid-packet
      send_a(32'h77777777);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_depo",    128'(d_a),  128'(0));
      chk("t6_gecerli", 128'(dv_a), 128'(0));
      chk("t6_hazir",   128'(hz_a), 128'(0));
      chk("t6_adet",    128'(ad_a), 128'(0));
      #1 rst_n = 1'b1;
      clear_all();
      send_a(32'h88888888);
      send_a(32'h99999999);
      chk("t6_clean",      128'(d_a),  128'(64'h99999999_88888888));
      chk("t6_clean_adet", 128'(ad_a), 128'(2));
      tick();

      // Flush on N=4
      ka = 32'hAAAA0001; kb = 32'hBBBB0002; kc = 32'hCCCC0003;
      send_c(ka, 1'b0);
      send_c(kb, 1'b0);
      send_c(kc, 1'b1);
      chk("t4_depo",    d_c,         {32'h0, kc, kb, ka});
      chk("t4_adet",    128'(ad_c),  128'(3));
      chk("t4_gecerli", 128'(dv_c),  128'(1));
      bos_c = 1'b1;
      tick();
      bos_c = 1'b0;
      chk("t4_empty_flush", 128'(dv_c), 128'(0));
      tick();
      chk("t4_empty_flush2", 128'(dv_c), 128'(0));

      // Flush ignored while the output is stuck, then re-pulsed
      send_c(32'h0000D00D, 1'b1);
      dh_c = 1'b0;
      send_c(32'h0000E00E, 1'b0);
      bos_c = 1'b1;
      tick();
      bos_c = 1'b0;
      chk("t4_blocked_depo", d_c,        128'(32'h0000D00D));
      chk("t4_blocked_adet", 128'(ad_c), 128'(1));
      dh_c = 1'b1;
      bos_c = 1'b1;
      tick();
      bos_c = 1'b0;
      chk("t4_repulse_depo",    d_c,        128'(32'h0000E00E));
      chk("t4_repulse_adet",    128'(ad_c), 128'(1));
      chk("t4_repulse_gecerli", 128'(dv_c), 128'(1));
      tick();
      chk("t4_final_drain", 128'(dv_c), 128'(0));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
